// File: rtl/axi_arb.sv
// axi_arb: shares one single-beat AXI master between an instruction-fetch port and a
// load/store port. Optional macro AXI_ARB_RR_EN enables round-robin read arbitration.
module axi_arb #(
    parameter logic [3:0] ID_BASE = 4'd0
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_valid,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_SEND = 2'd1,
        W_B    = 2'd2
    } w_state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    r_state_t    r_state_r;
    r_state_t    r_next_s;
    w_state_t    w_state_r;
    w_state_t    w_next_s;

    logic        owner_r;
    logic [3:0]  arid_r;
    logic [31:0] araddr_r;
    logic        arvalid_r;
    logic        rready_r;

    logic [31:0] awaddr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic        awvalid_r;
    logic        wvalid_r;
    logic        bready_r;

    logic        inst_cand_s;
    logic        data_cand_s;
    logic        grant_s;
    logic        grant_data_s;
    logic        ar_hs_s;
    logic        r_hs_s;
    logic        b_hs_s;
    logic        aw_fin_s;
    logic        w_fin_s;
    logic        load_busy_s;
    logic        store_acc_s;
    logic        store_ok_s;

    // Loads wait for the write side to drain so a load can never overtake a store.
    assign inst_cand_s = inst_req;
    assign data_cand_s = data_req && !data_wr && (w_state_r == W_IDLE);

    assign ar_hs_s = arvalid_r && arready;
    assign r_hs_s  = rready_r && rvalid;
    assign b_hs_s  = bready_r && bvalid;

    // A store is held off while a load owns the read channel, so the two data
    // completions can never collide on data_data_ok.
    assign load_busy_s = (r_state_r != R_IDLE) && (owner_r == OWN_DATA);

`ifdef AXI_ARB_RR_EN
    logic prio_inst_r;

    // Tie-break between simultaneous candidates using the round-robin pointer.
    always_comb begin
        if (data_cand_s && inst_cand_s) begin
            grant_data_s = !prio_inst_r;
        end else begin
            grant_data_s = data_cand_s;
        end
    end

    // Round-robin pointer: the requester granted last loses the next tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio_inst_r <= 1'b0;
        end else if (grant_s) begin
            prio_inst_r <= grant_data_s;
        end else begin
            prio_inst_r <= prio_inst_r;
        end
    end
`else
    assign grant_data_s = data_cand_s;
`endif

    // Read FSM next-state and grant decision.
    always_comb begin
        r_next_s = r_state_r;
        grant_s  = 1'b0;
        case (r_state_r)
            R_IDLE: begin
                if (inst_cand_s || data_cand_s) begin
                    grant_s  = 1'b1;
                    r_next_s = R_AR;
                end else begin
                    r_next_s = R_IDLE;
                end
            end
            R_AR: begin
                if (ar_hs_s) begin
                    r_next_s = R_R;
                end else begin
                    r_next_s = R_AR;
                end
            end
            R_R: begin
                if (r_hs_s) begin
                    r_next_s = R_IDLE;
                end else begin
                    r_next_s = R_R;
                end
            end
            default: begin
                r_next_s = R_IDLE;
            end
        endcase
    end

    // Read FSM state, owner and AR channel registers captured at grant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_r <= R_IDLE;
            owner_r   <= OWN_INST;
            arid_r    <= ID_BASE;
            araddr_r  <= 32'd0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
        end else begin
            r_state_r <= r_next_s;
            if (grant_s) begin
                owner_r  <= grant_data_s;
                arid_r   <= grant_data_s ? (ID_BASE + 4'd1) : ID_BASE;
                araddr_r <= grant_data_s ? data_addr : inst_addr;
            end else begin
                owner_r  <= owner_r;
                arid_r   <= arid_r;
                araddr_r <= araddr_r;
            end
            arvalid_r <= (r_next_s == R_AR);
            rready_r  <= (r_next_s == R_R);
        end
    end

    // A channel counts as finished once its valid has dropped or it handshakes now.
    assign aw_fin_s = !awvalid_r || awready;
    assign w_fin_s  = !wvalid_r || wready;

    // Write FSM next-state, store acceptance and store address acknowledge.
    always_comb begin
        w_next_s    = w_state_r;
        store_acc_s = 1'b0;
        store_ok_s  = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (data_req && data_wr && !load_busy_s) begin
                    store_acc_s = 1'b1;
                    w_next_s    = W_SEND;
                end else begin
                    w_next_s = W_IDLE;
                end
            end
            W_SEND: begin
                if (aw_fin_s && w_fin_s) begin
                    store_ok_s = 1'b1;
                    w_next_s   = W_B;
                end else begin
                    w_next_s = W_SEND;
                end
            end
            W_B: begin
                if (bvalid) begin
                    w_next_s = W_IDLE;
                end else begin
                    w_next_s = W_B;
                end
            end
            default: begin
                w_next_s = W_IDLE;
            end
        endcase
    end

    // Write FSM state plus AW/W/B channel registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state_r <= W_IDLE;
            awaddr_r  <= 32'd0;
            wdata_r   <= 32'd0;
            wstrb_r   <= 4'd0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
        end else begin
            w_state_r <= w_next_s;
            if (store_acc_s) begin
                awaddr_r  <= data_addr;
                wdata_r   <= data_wdata;
                wstrb_r   <= data_wstrb;
                awvalid_r <= 1'b1;
                wvalid_r  <= 1'b1;
            end else begin
                awaddr_r  <= awaddr_r;
                wdata_r   <= wdata_r;
                wstrb_r   <= wstrb_r;
                awvalid_r <= awvalid_r && !awready;
                wvalid_r  <= wvalid_r && !wready;
            end
            bready_r <= (w_next_s == W_B);
        end
    end

    assign arid    = arid_r;
    assign araddr  = araddr_r;
    assign arvalid = arvalid_r;
    assign rready  = rready_r;
    assign awaddr  = awaddr_r;
    assign awvalid = awvalid_r;
    assign wdata   = wdata_r;
    assign wstrb   = wstrb_r;
    assign wvalid  = wvalid_r;
    assign bready  = bready_r;

    assign inst_addr_ok = ar_hs_s && (owner_r == OWN_INST);
    assign inst_valid   = r_hs_s && (owner_r == OWN_INST);
    assign inst_rdata   = inst_valid ? rdata : 32'd0;

    assign data_addr_ok = (ar_hs_s && (owner_r == OWN_DATA)) || store_ok_s;
    assign data_data_ok = (r_hs_s && (owner_r == OWN_DATA)) || b_hs_s;
    assign data_rdata   = (r_hs_s && (owner_r == OWN_DATA)) ? rdata : 32'd0;

endmodule

// File: tb/tb_axi_arb.sv
// tb_axi_arb: table-driven per-cycle vectors for axi_arb plus hand-written sequences
// for the tie-arbitration and reset-during-read corner cases.
module tb_axi_arb;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_valid;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    axi_arb #(.ID_BASE(4'd0)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_valid(inst_valid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag order: arvalid rready awvalid wvalid bready inst_addr_ok inst_valid data_addr_ok data_data_ok
    logic [8:0]   flags;
    logic [176:0] all_out;
    assign flags   = {arvalid, rready, awvalid, wvalid, bready,
                      inst_addr_ok, inst_valid, data_addr_ok, data_data_ok};
    assign all_out = {flags, arid, araddr, awaddr, wdata, wstrb, inst_rdata, data_rdata};

    typedef struct {
        logic        ireq;
        logic        dreq;
        logic        dwr;
        logic [31:0] addr;
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        awready;
        logic        wready;
        logic        bvalid;
        logic [8:0]  eflags;
        logic [3:0]  earid;
        logic [31:0] earaddr;
        logic [31:0] eirdata;
        logic [31:0] edrdata;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic ireq, input logic dreq, input logic dwr, input logic [31:0] addr,
                       input logic ar_rdy, input logic r_vld, input logic [31:0] r_dat,
                       input logic aw_rdy, input logic w_rdy, input logic b_vld,
                       input logic [8:0] eflags, input logic [3:0] earid, input logic [31:0] earaddr,
                       input logic [31:0] eirdata, input logic [31:0] edrdata);
        vec_t v;
        v.ireq = ireq;       v.dreq = dreq;       v.dwr = dwr;        v.addr = addr;
        v.arready = ar_rdy;  v.rvalid = r_vld;    v.rdata = r_dat;
        v.awready = aw_rdy;  v.wready = w_rdy;    v.bvalid = b_vld;
        v.eflags = eflags;   v.earid = earid;     v.earaddr = earaddr;
        v.eirdata = eirdata; v.edrdata = edrdata;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    logic [35:0] got_g  [3];
    logic [35:0] exp_g  [3];
    int          n_g;
    logic        got_done;

    initial begin
        resetn = 1'b0;   inst_req = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_wr = 1'b0;  data_addr = 32'd0;
        data_wstrb = 4'hF; data_wdata = 32'hA5A5_5A5A;
        arready = 1'b0;  rvalid = 1'b0;   rdata = 32'd0;
        awready = 1'b0;  wready = 1'b0;   bvalid = 1'b0;

        // fetch 0x1C000000, arready and rvalid each one cycle late
        add(1'b1, 1'b0, 1'b0, 32'h1C00_0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 9'b000000000, 4'd0, 32'h0000_0000, 32'd0, 32'd0);
        add(1'b1, 1'b0, 1'b0, 32'h1C00_0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 9'b100000000, 4'd0, 32'h1C00_0000, 32'd0, 32'd0);
        add(1'b1, 1'b0, 1'b0, 32'h1C00_0000, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 9'b100001000, 4'd0, 32'h1C00_0000, 32'd0, 32'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 9'b010000000, 4'd0, 32'h1C00_0000, 32'd0, 32'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 9'b010000100, 4'd0, 32'h1C00_0000, 32'h1234_5678, 32'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 9'b000000000, 4'd0, 32'h1C00_0000, 32'd0, 32'd0);
        // plain load from 0x200, zero-wait slave
        add(1'b0, 1'b1, 1'b0, 32'h0000_0200, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 9'b000000000, 4'd0, 32'h1C00_0000, 32'd0, 32'd0);
        add(1'b0, 1'b1, 1'b0, 32'h0000_0200, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 9'b100000010, 4'd1, 32'h0000_0200, 32'd0, 32'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 9'b010000001, 4'd1, 32'h0000_0200, 32'd0, 32'hCAFE_F00D);
        add(1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 9'b000000000, 4'd1, 32'h0000_0200, 32'd0, 32'd0);
        // store to 0x40 with awready and wready in the same cycle
        add(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 9'b000000000, 4'd1, 32'h0000_0200, 32'd0, 32'd0);
        add(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 9'b001100010, 4'd1, 32'h0000_0200, 32'd0, 32'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 9'b000010000, 4'd1, 32'h0000_0200, 32'd0, 32'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 9'b000010001, 4'd1, 32'h0000_0200, 32'd0, 32'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 9'b000000000, 4'd1, 32'h0000_0200, 32'd0, 32'd0);
        // store to 0x100, wready two cycles after awready, then an immediate load from 0x100
        add(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 9'b000000000, 4'd1, 32'h0000_0200, 32'd0, 32'd0);
        add(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 9'b001100000, 4'd1, 32'h0000_0200, 32'd0, 32'd0);
        add(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 9'b001100000, 4'd1, 32'h0000_0200, 32'd0, 32'd0);
        add(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 9'b000100000, 4'd1, 32'h0000_0200, 32'd0, 32'd0);
        add(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 9'b000100010, 4'd1, 32'h0000_0200, 32'd0, 32'd0);
        add(1'b0, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 9'b000010000, 4'd1, 32'h0000_0200, 32'd0, 32'd0);
        add(1'b0, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 9'b000010000, 4'd1, 32'h0000_0200, 32'd0, 32'd0);
        add(1'b0, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 9'b000010001, 4'd1, 32'h0000_0200, 32'd0, 32'd0);
        add(1'b0, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 9'b000000000, 4'd1, 32'h0000_0200, 32'd0, 32'd0);
        add(1'b0, 1'b1, 1'b0, 32'h0000_0100, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 9'b100000010, 4'd1, 32'h0000_0100, 32'd0, 32'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h0BAD_BEEF, 1'b0, 1'b0, 1'b0, 9'b010000001, 4'd1, 32'h0000_0100, 32'd0, 32'h0BAD_BEEF);
        add(1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 9'b000000000, 4'd1, 32'h0000_0100, 32'd0, 32'd0);

        repeat (3) @(negedge clk);
        #2;
        check("reset_state", {15'd0, all_out}, 192'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            inst_req  = vecs[i].ireq;    data_req = vecs[i].dreq;  data_wr = vecs[i].dwr;
            inst_addr = vecs[i].addr;    data_addr = vecs[i].addr;
            arready   = vecs[i].arready; rvalid = vecs[i].rvalid;  rdata = vecs[i].rdata;
            awready   = vecs[i].awready; wready = vecs[i].wready;  bvalid = vecs[i].bvalid;
            #2;
            check($sformatf("vec%0d", i),
                  {83'd0, flags, arid, araddr, inst_rdata, data_rdata},
                  {83'd0, vecs[i].eflags, vecs[i].earid, vecs[i].earaddr, vecs[i].eirdata, vecs[i].edrdata});
        end
        check("store_regs", {124'd0, awaddr, wdata, wstrb}, {124'd0, 32'h0000_0100, 32'hA5A5_5A5A, 4'hF});

        // Three back-to-back ties between fetch and load after a fresh reset.
`ifdef AXI_ARB_RR_EN
        exp_g[0] = {4'd1, 32'h0000_2000};
        exp_g[1] = {4'd0, 32'h0000_1000};
        exp_g[2] = {4'd1, 32'h0000_2000};
`else
        exp_g[0] = {4'd1, 32'h0000_2000};
        exp_g[1] = {4'd1, 32'h0000_2000};
        exp_g[2] = {4'd1, 32'h0000_2000};
`endif
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        inst_req = 1'b1;  inst_addr = 32'h0000_1000;
        data_req = 1'b1;  data_wr = 1'b0;  data_addr = 32'h0000_2000;
        arready = 1'b1;   rvalid = 1'b1;   rdata = 32'd0;
        n_g = 0;
        for (int i = 0; i < 30 && n_g < 3; i++) begin
            @(negedge clk);
            #2;
            if (arvalid && arready) begin
                got_g[n_g] = {arid, araddr};
                n_g++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (k < n_g) begin
                check($sformatf("tie_grant%0d", k), {156'd0, got_g[k]}, {156'd0, exp_g[k]});
            end else begin
                n_vec++;
                n_err++;
                $display("FAIL tie_grant%0d: no grant seen, expected %h", k, exp_g[k]);
            end
        end
        @(negedge clk);
        inst_req = 1'b0;
        data_req = 1'b0;
        repeat (6) @(negedge clk);
        arready = 1'b0;
        rvalid  = 1'b0;

        // Reset while the read is waiting in R_R with rvalid pending.
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'h0000_3000; arready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        inst_req = 1'b0; arready = 1'b0;
        #2;
        check("in_r_state_rready", {191'd0, rready}, {191'd0, 1'b1});
        rvalid = 1'b1;
        rdata  = 32'h0000_0055;
        #1;
        resetn = 1'b0;
        #1;
        check("reset_mid_read", {15'd0, all_out}, 192'd0);
        @(negedge clk);
        resetn = 1'b1;
        rvalid = 1'b0;
        rdata  = 32'd0;

        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_4000;
        arready = 1'b1;  rvalid = 1'b1;  rdata = 32'h0000_0077;
        got_done = 1'b0;
        for (int i = 0; i < 10 && !got_done; i++) begin
            @(negedge clk);
            #2;
            if (data_data_ok) begin
                got_done = 1'b1;
                check("load_after_reset", {160'd0, data_rdata}, {160'd0, 32'h0000_0077});
            end
            if (data_addr_ok) begin
                data_req = 1'b0;
            end
        end
        if (!got_done) begin
            n_vec++;
            n_err++;
            $display("FAIL load_after_reset: no data_data_ok within 10 cycles, expected rdata 00000077");
        end
        data_req = 1'b0;
        arready  = 1'b0;
        rvalid   = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
